approx_mul_pipe: RTL and testbench
==================================

# approx_mul_pipe

Parametrised, pipelined unsigned W×W multiplier with a per-transaction mode select: exact product, or truncated-and-compensated approximate product. It is the streaming successor to the fixed 8×8 combinational approximate multiplier and sits between operand sources and accumulators in the datapath. It adds valid/ready flow control, three pipeline stages with bubble collapse, and a saturating counter of approximate transactions for error-budget monitoring.

## Interface
- `W`, default 8: operand width; legal range 4..16.
- `TRUNC`, default 5: approximate mode drops partial-product columns 0..TRUNC-1; legal range 0..2W-1.
- `COMP`, default 6: compensation constant added in approximate mode; must be < 2^(2W).
- `CNT_W`, default 32: width of the approximate-transaction counter.
- `CLK`, in, 1: single clock, rising edge.
- `RST_N`, in, 1: asynchronous active-low reset. Assertion is asynchronous; release is synchronous to `CLK`, via an external synchroniser.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: stage 1 can accept.
- `in_a`, in, W: multiplicand.
- `in_b`, in, W: multiplier.
- `in_mode`, in, 1: 0 = exact, 1 = approximate.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts.
- `out_p`, out, 2W: product.
- `out_mode`, out, 1: mode tag carried with the result.
- `cnt_clr`, in, 1: synchronous clear of `approx_cnt`.
- `approx_cnt`, out, CNT_W: saturating count of approximate results delivered.

## Operation
- **Exact result:** P = a·b.
- **Approximate result:** P = (Σ a_i·b_j·2^(i+j) over i+j ≥ TRUNC, + COMP) mod 2^(2W).
  - With TRUNC = 0, P equals a·b + COMP, taken mod 2^(2W).
- **Stage 1 (S1):** registers a, b, mode and the valid bit.
- **Stage 2 (S2):** generates the partial products, zeroes columns below TRUNC when mode = 1, and injects COMP as an extra row when mode = 1. It reduces everything to two rows (sum and carry), 2W bits each, through a carry-save tree of full adders, half adders and exact 4:2 compressors. The two rows are registered together with mode and valid.
- **Stage 3 (S3):** a carry-propagate add of the two rows, with the carry-out beyond 2W bits discarded. Registers `out_p`, `out_mode` and `out_valid`.
- **Flow control:**
  - ready_k = !valid_k | ready_(k+1), with ready_4 = `out_ready`.
  - `in_ready` = ready_1.
  - A stage loads when its ready_k is high. Its valid bit takes valid_(k-1), or `in_valid` for S1.
  - Data registers load only when the incoming valid is 1; they hold otherwise.
- **Counter:**
  - Increments on each output handshake (`out_valid` & `out_ready`) with `out_mode` = 1.
  - Saturates at 2^CNT_W − 1.
  - `cnt_clr` takes priority over an increment in the same cycle; the result is 0.
- **Invalid mode values:** none exist; `in_mode` is 1 bit.

## Timing
- **Latency:** 3 cycles from input handshake to `out_valid`, with no stalls.
- **Throughput:** 1 result per cycle while `out_ready` = 1.
- **Backpressure:**
  - While `out_ready` = 0 and `out_valid` = 1, `out_p` and `out_mode` hold stable.
  - Upstream bubbles collapse, so up to 3 transactions are held in flight.
  - `in_ready` drops only when all three stages are valid.
- **Simultaneous handshakes:** an input and an output handshake in the same cycle with a full pipeline is legal and loses no data.
- **Reset values:** all valid bits 0, `in_ready` 1, `out_valid` 0, `out_p` 0, `out_mode` 0, `approx_cnt` 0.
- **Reset mid-stream:** in-flight transactions are discarded and no partial result is emitted. The first input accepted after reset release appears 3 cycles later.
- `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output paths exist.

## Structure
- **Package `approx_mul_pkg`:**
  - `mode_e` enum: `MODE_EXACT` = 0, `MODE_APPROX` = 1.
  - Function `approx_ref(a, b, trunc, comp)`, shared by the RTL assertions and the bench model.
  - Parameter-legality checks.
- **Sub-module `approx_mul_csa_tree`:**
  - Purely combinational, parametrised on W and TRUNC.
  - Inputs: a, b, mode. Outputs: sum and carry rows.
  - Built from the existing `FA`, `HA` and `exact_4to2_compressor` cells.
  - Instanced in S2.

## Test plan
All values below use W = 8, TRUNC = 5, COMP = 6.
1. Mode 0, a = 255, b = 255 → P = 65025 after 3 cycles. Mode 1 with the same operands → 64902; the dropped columns sum to 129.
2. Mode 1, a = 1, b = 1 → 6. Mode 1, a = 16, b = 2 → 38. Mode 1, a = 0, b = 200 → 6. Mode 0, a = 0, b = 200 → 0.
3. Back-to-back stream of 1000 random operands with random modes, `out_ready` = 1 → one result per cycle, each matching `approx_ref` or a·b. `approx_cnt` equals the number of mode-1 transactions.
4. Random `out_ready` (50%) and random `in_valid` gaps → no loss, duplication or reordering. `out_p` stays stable under stall. `in_ready` = 0 only when 3 transactions are in flight.
5. Preload `approx_cnt` to max via a CNT_W = 4 build, then send 3 more mode-1 results → count stays at 15. `cnt_clr` asserted in the same cycle as a mode-1 handshake → 0.
6. Assert `RST_N` low with 3 valid transactions in flight → `out_valid` = 0 immediately and all outputs 0. After release, the next input appears exactly 3 cycles later with no stale output in between.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
//   mode_e     : per-transaction mode tag (exact / truncated-approximate)
//   approx_ref : behavioural approximate product, column-truncated plus
//                compensation constant, used by the in-RTL consistency check
//   params_ok  : legality check for W / TRUNC / COMP
package approx_mul_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int MAX_W = 16;
  localparam logic [2*MAX_W-1:0] REF_ONE = 32'd1;

  // Sum of the kept partial-product bits (column i+j >= trunc) plus comp.
  // The caller truncates the result to its own 2W-bit width.
  function automatic logic [2*MAX_W-1:0] approx_ref(
    input logic [MAX_W-1:0]   a,
    input logic [MAX_W-1:0]   b,
    input int                 trunc,
    input logic [2*MAX_W-1:0] comp
  );
    logic [2*MAX_W-1:0] p;
    p = comp;
    for (int i = 0; i < MAX_W; i++)
      for (int j = 0; j < MAX_W; j++)
        if (a[i] && b[j] && (i + j) >= trunc) p = p + (REF_ONE << (i + j));
    return p;
  endfunction

  function automatic bit params_ok(input int w, input int trunc, input longint comp);
    return (w >= 4) && (w <= MAX_W) && (trunc >= 0) && (trunc <= 2*w - 1) &&
           (comp >= 0) && (comp < (longint'(1) << (2*w)));
  endfunction

endpackage

// File: rtl/FA.sv
// Full adder cell: s = a ^ b ^ ci, co = majority(a, b, ci).
module FA (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/HA.sv
// Half adder cell: s = a ^ b, co = a & b.
module HA (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

// File: rtl/approx_mul_csa_tree.sv
// Combinational carry-save reduction for the S2 stage.
//   a, b  : operands
//   mode  : MODE_APPROX zeroes columns < TRUNC and injects COMP as an extra row
//   sum, carry : two 2W-bit rows whose sum (mod 2^2W) is the product
// W partial-product rows plus the COMP row are folded two at a time into a
// running (sum, carry) pair with 4:2 compressor rows; an odd leftover row is
// absorbed with one FA row. Carries past bit 2W-1 are dropped (mod 2^2W).
module approx_mul_csa_tree
  import approx_mul_pkg::*;
#(
  parameter int          W     = 8,
  parameter int          TRUNC = 5,
  parameter int unsigned COMP  = 6
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  mode_e          mode,
  output logic [2*W-1:0] sum,
  output logic [2*W-1:0] carry
);
  localparam int P = 2*W;
  localparam int N = W + 1;
  localparam int K = (N - 2) / 2;
  localparam bit ODD_ROW = ((N - 2) % 2) == 1;
  localparam logic [P-1:0] LOW      = (P'(1) << TRUNC) - P'(1);
  localparam logic [P-1:0] COMP_ROW = P'(COMP);

  logic [N-1:0][P-1:0] row;

  always_comb begin
    row = '0;
    for (int j = 0; j < W; j++)
      row[j] = ({{W{1'b0}}, a & {W{b[j]}}} << j) & ((mode == MODE_APPROX) ? ~LOW : '1);
    row[N-1] = (mode == MODE_APPROX) ? COMP_ROW : '0;
  end

  for (genvar k = 0; k < K; k++) begin : g_c42
    logic [P-1:0] x1, x2, s, cy, co, ci;
    logic unused_msb;
    if (k == 0) begin : g_src
      assign x1 = row[0];
      assign x2 = row[1];
    end else begin : g_src
      assign x1 = g_c42[k-1].s;
      assign x2 = {g_c42[k-1].cy[P-2:0], 1'b0};
    end
    assign ci = {co[P-2:0], 1'b0};
    for (genvar i = 0; i < P; i++) begin : g_bit
      exact_4to2_compressor u_cmp (
        .x1(x1[i]), .x2(x2[i]), .x3(row[2*k+2][i]), .x4(row[2*k+3][i]),
        .cin(ci[i]), .sum(s[i]), .carry(cy[i]), .cout(co[i]));
    end
    assign unused_msb = co[P-1] ^ cy[P-1];
  end

  logic [P-1:0] fs, fc;
  assign fs = g_c42[K-1].s;
  assign fc = {g_c42[K-1].cy[P-2:0], 1'b0};

  if (ODD_ROW) begin : g_last
    logic [P-1:0] s, cy;
    logic unused_bits;
    // fc[0] is always 0 (shifted carry row), so bit 0 only needs a HA
    HA u_ha (.a(fs[0]), .b(row[N-1][0]), .s(s[0]), .co(cy[0]));
    for (genvar i = 1; i < P; i++) begin : g_bit
      FA u_fa (.a(fs[i]), .b(fc[i]), .ci(row[N-1][i]), .s(s[i]), .co(cy[i]));
    end
    assign sum   = s;
    assign carry = {cy[P-2:0], 1'b0};
    assign unused_bits = cy[P-1] ^ fc[0];
  end else begin : g_last
    assign sum   = fs;
    assign carry = fc;
  end

endmodule

// File: rtl/exact_4to2_compressor.sv
// Exact 4:2 compressor: x1+x2+x3+x4+cin = sum + 2*(carry + cout).
// cout depends only on x1..x3, so a row of these never forms a ripple loop
// through cin.
module exact_4to2_compressor (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic cin,
  output logic sum,
  output logic carry,
  output logic cout
);
  logic s1;

  FA u_fa0 (.a(x1), .b(x2), .ci(x3),  .s(s1),  .co(cout));
  FA u_fa1 (.a(s1), .b(x4), .ci(cin), .s(sum), .co(carry));
endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage valid/ready W x W unsigned multiplier, exact or approximate
// per transaction, with a saturating count of approximate results delivered.
//   CLK, RST_N          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_a, in_b, in_mode)
//   out_valid/out_ready : result handshake (out_p, out_mode)
//   cnt_clr, approx_cnt : sync clear / saturating approximate-result count
// Each stage loads when it is empty or the stage after it drains, so
// bubbles collapse and in_ready drops only with all three stages full.
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int          W     = 8,
  parameter int          TRUNC = 5,
  parameter int unsigned COMP  = 6,
  parameter int          CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_p,
  output logic             out_mode,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] approx_cnt
);
  localparam int STAGES = 3;
  localparam int P = 2*W;

  if (!params_ok(W, TRUNC, longint'(COMP))) begin : g_param_err
    $error("approx_mul_pipe: illegal W/TRUNC/COMP");
  end

  logic [STAGES:1]   vld_pipe;
  logic [STAGES+1:1] rdy;
  logic [W-1:0]      a1, b1;
  mode_e             m1, m2, m3;
  logic [P-1:0]      tree_s, tree_c, s2, c2, model_p;

  always_comb begin
    rdy = '0;
    rdy[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) rdy[k] = !vld_pipe[k] || rdy[k+1];
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_pipe[STAGES];
  assign out_mode  = m3;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) vld_pipe <= '0;
    else begin
      if (rdy[1]) vld_pipe[1] <= in_valid;
      for (int k = 2; k <= STAGES; k++)
        if (rdy[k]) vld_pipe[k] <= vld_pipe[k-1];
    end

  // S1: operand capture
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      a1 <= '0;
      b1 <= '0;
      m1 <= MODE_EXACT;
    end else if (rdy[1] && in_valid) begin
      a1 <= in_a;
      b1 <= in_b;
      m1 <= mode_e'(in_mode);
    end

  approx_mul_csa_tree #(.W(W), .TRUNC(TRUNC), .COMP(COMP)) u_tree (
    .a(a1), .b(b1), .mode(m1), .sum(tree_s), .carry(tree_c));

  // Reference value for the consistency assertion only; no datapath use.
  always_comb
    model_p = (m1 == MODE_APPROX) ? P'(approx_ref(16'(a1), 16'(b1), TRUNC, COMP))
                                  : P'(a1) * P'(b1);

  // S2: carry-save rows
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s2 <= '0;
      c2 <= '0;
      m2 <= MODE_EXACT;
    end else if (rdy[2] && vld_pipe[1]) begin
      s2 <= tree_s;
      c2 <= tree_c;
      m2 <= m1;
      assert (P'(tree_s + tree_c) == model_p);
    end

  // S3: carry-propagate add, carry-out beyond 2W discarded
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      out_p <= '0;
      m3    <= MODE_EXACT;
    end else if (rdy[3] && vld_pipe[2]) begin
      out_p <= s2 + c2;
      m3    <= m2;
    end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) approx_cnt <= '0;
    else if (cnt_clr) approx_cnt <= '0;
    else if (out_valid && out_ready && m3 == MODE_APPROX && approx_cnt != '1)
      approx_cnt <= approx_cnt + CNT_W'(1);

endmodule

// File: tb/tb_approx_mul_pipe.sv
module tb_approx_mul_pipe;
  localparam int W = 8, TRUNC = 5, COMP = 6;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, cnt_clr;
  logic [W-1:0] in_a, in_b;
  logic [2*W-1:0] out_p;
  logic [31:0] approx_cnt;

  logic v2, r2, m2i, ov2, or2, om2, clr2;
  logic [7:0] a2, b2;
  logic [15:0] p2;
  logic [3:0] cnt2;

  approx_mul_pipe #(.W(W), .TRUNC(TRUNC), .COMP(COMP), .CNT_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_mode(out_mode),
    .cnt_clr(cnt_clr), .approx_cnt(approx_cnt));

  approx_mul_pipe #(.W(W), .TRUNC(TRUNC), .COMP(COMP), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(v2), .in_ready(r2),
    .in_a(a2), .in_b(b2), .in_mode(m2i), .out_valid(ov2),
    .out_ready(or2), .out_p(p2), .out_mode(om2),
    .cnt_clr(clr2), .approx_cnt(cnt2));

  int checks = 0, errors = 0, cyc = 0, n_approx = 0;
  typedef struct { logic [15:0] p; logic m; int t; } txn_t;
  txn_t q[$];
  logic stall_prev, m_prev;
  logic [15:0] p_prev, dir_exp;
  bit lat_mode, use_dir;

  logic [7:0]  da [6] = '{8'd255, 8'd255, 8'd1, 8'd16, 8'd0, 8'd0};
  logic [7:0]  db [6] = '{8'd255, 8'd255, 8'd1, 8'd2, 8'd200, 8'd200};
  logic        dm [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] dp [6] = '{16'd65025, 16'd64902, 16'd6, 16'd38, 16'd6, 16'd0};

  // Exact product minus the low triangle of dropped columns, plus COMP.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    int unsigned prod, lost;
    logic [31:0] r;
    prod = 32'(a) * 32'(b);
    r = prod;
    if (!m) return r[15:0];
    lost = 0;
    for (int i = 0; i < TRUNC && i < 8; i++)
      if (a[i]) lost += (32'(b) & ((32'd1 << (TRUNC - i)) - 1)) << i;
    r = prod - lost + COMP;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle on the main DUT: inputs already driven at the negedge.
  task automatic step();
    txn_t t;
    #1;
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_p", out_p, p_prev);
      chk("stall_mode", out_mode, m_prev);
    end
    chk("in_ready", in_ready, !(q.size() == 3 && !out_ready));
    if (lat_mode) chk("latency", out_valid, q.size() > 0 && (cyc - q[0].t) == 3);
    else if (q.size() == 0) chk("spurious", out_valid, 0);
    if (out_valid && out_ready && q.size() > 0) begin
      t = q.pop_front();
      chk("out_p", out_p, t.p);
      chk("out_mode", out_mode, t.m);
      if (t.m) n_approx++;
    end
    stall_prev = out_valid && !out_ready;
    p_prev = out_p;
    m_prev = out_mode;
    if (in_valid && in_ready) begin
      t.p = use_dir ? dir_exp : model(in_a, in_b, in_mode);
      t.m = in_mode;
      t.t = cyc;
      q.push_back(t);
    end
    @(negedge CLK);
    cyc++;
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; out_ready = 1; cnt_clr = 0;
    v2 = 0; a2 = 0; b2 = 0; m2i = 1; or2 = 1; clr2 = 0;
    stall_prev = 0; p_prev = 0; m_prev = 0; dir_exp = 0; lat_mode = 1; use_dir = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_cnt", approx_cnt, 0);
    chk("rst_cnt4", cnt2, 0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;

    // directed operands, back to back
    use_dir = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_a = da[k]; in_b = db[k]; in_mode = dm[k]; dir_exp = dp[k];
      step();
    end
    in_valid = 0; use_dir = 0;
    repeat (5) step();

    // full-rate random stream
    for (int k = 0; k < 1000; k++) begin
      in_valid = 1; in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      step();
    end
    in_valid = 0;
    repeat (5) step();
    chk("stream_drained", q.size(), 0);
    chk("stream_cnt", approx_cnt, n_approx);

    // random gaps and backpressure
    lat_mode = 0;
    for (int k = 0; k < 2000; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    in_valid = 0; out_ready = 1;
    repeat (6) step();
    chk("bp_drained", q.size(), 0);
    chk("bp_cnt", approx_cnt, n_approx);

    // reset with a full pipeline
    out_ready = 0; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 1;
      step();
    end
    chk("inflight", q.size(), 3);
    in_valid = 0;
    #1 RST_N = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_p", out_p, 0);
    chk("mid_rst_out_mode", out_mode, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cnt", approx_cnt, 0);
    q.delete(); stall_prev = 0;
    @(negedge CLK);
    RST_N = 1'b1; out_ready = 1; lat_mode = 1;
    use_dir = 1; in_valid = 1; in_a = 16; in_b = 2; in_mode = 1; dir_exp = 16'd38;
    step();
    in_valid = 0; use_dir = 0;
    repeat (5) step();
    chk("post_rst_drained", q.size(), 0);

    // saturation on the 4-bit counter build
    a2 = 8'd3; b2 = 8'd5; m2i = 1; or2 = 1;
    v2 = 1; repeat (15) @(negedge CLK);
    v2 = 0; repeat (5) @(negedge CLK);
    #1;
    chk("cnt4_fill", cnt2, 15);
    chk("cnt4_in_ready", r2, 1);
    v2 = 1; repeat (3) @(negedge CLK);
    v2 = 0; repeat (5) @(negedge CLK);
    #1;
    chk("cnt4_sat", cnt2, 15);
    chk("cnt4_p", p2, model(a2, b2, 1'b1));
    clr2 = 1; @(negedge CLK);
    clr2 = 0; #1;
    chk("cnt4_clr", cnt2, 0);
    v2 = 1; @(negedge CLK);
    v2 = 0;
    for (int i = 0; i < 8 && !ov2; i++) @(negedge CLK);
    chk("cnt4_hs_valid", ov2, 1);
    chk("cnt4_hs_mode", om2, 1);
    clr2 = 1; @(negedge CLK);
    clr2 = 0; #1;
    chk("cnt4_clr_prio", cnt2, 0);
    chk("cnt4_hs_done", ov2, 0);
    v2 = 1; @(negedge CLK);
    v2 = 0; repeat (5) @(negedge CLK);
    #1;
    chk("cnt4_inc", cnt2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
